// File: rtl/dsp_addsub_pipe.sv
// Pipelined add/sub/compare unit: WIDTH-bit carry chain split into CHUNK-bit
// slices, one register stage per slice, valid/ready handshake with full-pipe stall.
module dsp_addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NSTAGE = WIDTH / CHUNK;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SLT  = 2'b10;
  localparam logic [1:0] OP_SLTU = 2'b11;

  if (CHUNK < 1) begin : g_bad_chunk
    $error("dsp_addsub_pipe: CHUNK must be at least 1");
  end else if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("dsp_addsub_pipe: WIDTH must be a multiple of CHUNK");
  end

  logic stall;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  // Stage k sees the untouched operand bits from slice k upward and the
  // finished sum bits below slice k; each stage resolves exactly one slice.
  for (genvar k = 0; k < NSTAGE; k++) begin : stg
    localparam int LO = k * CHUNK;
    localparam int HI = LO + CHUNK - 1;

    logic             v_i;
    logic [TAG_W-1:0] tag_i;
    logic [1:0]       op_i;
    logic             c_i;
    logic [WIDTH-1:LO] a_i;
    logic [WIDTH-1:LO] bx_i;
    logic [CHUNK:0]   sl;
    logic [HI:0]      sum_o;

    assign sl = {1'b0, a_i[HI:LO]} + {1'b0, bx_i[HI:LO]} + {{CHUNK{1'b0}}, c_i};

    if (k == 0) begin : g_first
      assign v_i   = in_valid;
      assign tag_i = in_tag;
      assign op_i  = in_op;
      assign c_i   = (in_op != OP_ADD);
      assign a_i   = in_a;
      assign bx_i  = (in_op == OP_ADD) ? in_b : ~in_b;
      assign sum_o = sl[CHUNK-1:0];
    end else begin : g_next
      assign v_i   = stg[k-1].g_reg.q_v;
      assign tag_i = stg[k-1].g_reg.q_tag;
      assign op_i  = stg[k-1].g_reg.q_op;
      assign c_i   = stg[k-1].g_reg.q_c;
      assign a_i   = stg[k-1].g_reg.q_a;
      assign bx_i  = stg[k-1].g_reg.q_bx;
      assign sum_o = {sl[CHUNK-1:0], stg[k-1].g_reg.q_sum};
    end

    if (k < NSTAGE - 1) begin : g_reg
      logic                q_v;
      logic [TAG_W-1:0]    q_tag;
      logic [1:0]          q_op;
      logic                q_c;
      logic [WIDTH-1:HI+1] q_a;
      logic [WIDTH-1:HI+1] q_bx;
      logic [HI:0]         q_sum;

      always_ff @(posedge clk) begin
        if (rst) begin
          q_v   <= 1'b0;
          q_tag <= '0;
          q_op  <= '0;
          q_c   <= 1'b0;
          q_a   <= '0;
          q_bx  <= '0;
          q_sum <= '0;
        end else if (!stall) begin
          q_v   <= v_i;
          q_tag <= tag_i;
          q_op  <= op_i;
          q_c   <= sl[CHUNK];
          q_a   <= a_i[WIDTH-1:HI+1];
          q_bx  <= bx_i[WIDTH-1:HI+1];
          q_sum <= sum_o;
        end
      end
    end else begin : g_out
      logic             carry_w;
      logic             ovf_w;
      logic             zero_w;
      logic [WIDTH-1:0] res_w;

      always_comb begin
        carry_w = sl[CHUNK];
        ovf_w   = (a_i[WIDTH-1] == bx_i[WIDTH-1]) && (sum_o[WIDTH-1] != a_i[WIDTH-1]);
        zero_w  = (sum_o == '0);
        res_w   = sum_o;
        if (op_i == OP_SLT) begin
          res_w = {{(WIDTH-1){1'b0}}, sum_o[WIDTH-1] ^ ovf_w};
        end else if (op_i == OP_SLTU) begin
          res_w = {{(WIDTH-1){1'b0}}, ~carry_w};
        end
      end

      // Data registers only load on a valid op so bubbles leave the last result visible.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_valid  <= 1'b0;
          out_result <= '0;
          out_tag    <= '0;
          out_carry  <= 1'b0;
          out_ovf    <= 1'b0;
          out_zero   <= 1'b0;
        end else if (!stall) begin
          out_valid <= v_i;
          if (v_i) begin
            out_result <= res_w;
            out_tag    <= tag_i;
            out_carry  <= carry_w;
            out_ovf    <= ovf_w;
            out_zero   <= zero_w;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dsp_addsub_pipe.sv
// Directed bench for dsp_addsub_pipe: vector table with hand-computed results,
// plus streaming, backpressure and mid-flight reset sequences.
module tb_dsp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        out_carry;
  logic        out_ovf;
  logic        out_zero;

  int n_chk  = 0;
  int n_fail = 0;

  dsp_addsub_pipe #(.WIDTH(32), .CHUNK(16), .TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_carry(out_carry), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, r;
    logic        c, o, z;
  } vec_t;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [4:0]  tag;
  } op_t;

  typedef struct {
    logic [31:0] r;
    logic [4:0]  tag;
    logic        c, o, z;
  } exp_t;

  op_t  stim_q[$];
  exp_t exp_q[$];
  int   first_acc, first_con, last_con, n_con;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Behavioural reference using whole-word arithmetic.
  function automatic exp_t model(input op_t s);
    exp_t        e;
    logic [32:0] w;
    if (s.op == 2'b00) w = {1'b0, s.a} + {1'b0, s.b};
    else               w = {1'b0, s.a} - {1'b0, s.b};
    e.tag = s.tag;
    e.c   = (s.op == 2'b00) ? w[32] : !w[32];
    if (s.op == 2'b00) e.o = (s.a[31] == s.b[31]) && (w[31] != s.a[31]);
    else               e.o = (s.a[31] != s.b[31]) && (w[31] != s.a[31]);
    e.z = (w[31:0] == 32'd0);
    case (s.op)
      2'b10:   e.r = {31'd0, $signed(s.a) < $signed(s.b)};
      2'b11:   e.r = {31'd0, s.a < s.b};
      default: e.r = w[31:0];
    endcase
    return e;
  endfunction

  // Entered and left at posedge+1.
  task automatic do_single(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] tag, input logic [31:0] r,
                           input logic c, input logic o, input logic z);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("latency_early", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("latency_valid", 32'(out_valid), 32'd1);
    chk("result", out_result, r);
    chk("tag", 32'(out_tag), 32'(tag));
    chk("carry", 32'(out_carry), 32'(c));
    chk("ovf", 32'(out_ovf), 32'(o));
    chk("zero", 32'(out_zero), 32'(z));
    @(posedge clk); #1;
    chk("drained", 32'(out_valid), 32'd0);
  endtask

  // Streams stim_q through the DUT; out_ready is low for cycles < ready_low.
  task automatic run_stream(input int ready_low);
    int          cyc = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_r;
    logic [4:0]  prev_t;
    exp_t        e;
    first_acc = -1; first_con = -1; last_con = -1; n_con = 0;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && cyc < 200) begin
      out_ready = (cyc >= ready_low);
      if (stim_q.size() > 0) begin
        in_valid = 1'b1; in_op = stim_q[0].op; in_a = stim_q[0].a;
        in_b = stim_q[0].b; in_tag = stim_q[0].tag;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("in_ready", 32'(in_ready), 32'(!(cyc >= 2 && cyc < ready_low)));
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_result", out_result, prev_r);
        chk("hold_tag", 32'(out_tag), 32'(prev_t));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(stim_q[0]));
        void'(stim_q.pop_front());
        if (first_acc < 0) first_acc = cyc;
      end
      if (out_valid && out_ready) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL stream_extra: got unexpected result 0x%08h tag %0d", out_result, out_tag);
        end else begin
          e = exp_q.pop_front();
          chk("stream_result", out_result, e.r);
          chk("stream_tag", 32'(out_tag), 32'(e.tag));
          chk("stream_flags", {29'd0, out_carry, out_ovf, out_zero}, {29'd0, e.c, e.o, e.z});
        end
        if (first_con < 0) first_con = cyc;
        last_con = cyc;
        n_con++;
      end
      prev_stall = out_valid && !out_ready;
      prev_r = out_result;
      prev_t = out_tag;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_timeout", 32'(cyc >= 200), 32'd0);
    #1;
    chk("stream_no_dup", 32'(out_valid), 32'd0);
  endtask

  initial begin
    vec_t vecs[13];
    vecs[0]  = '{2'b00, 32'h0000FFFF, 32'h00000001, 32'h00010000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{2'b01, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{2'b10, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{2'b11, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{2'b11, 32'h00000001, 32'h00000002, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{2'b00, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{2'b00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{2'b10, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{2'b10, 32'h80000000, 32'h00000001, 32'h00000001, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{2'b11, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{2'b01, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{2'b00, 32'h12348000, 32'h00018000, 32'h12360000, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_a = '0; in_b = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_result", out_result, 32'd0);
    chk("reset_tag", 32'(out_tag), 32'd0);
    chk("reset_flags", {29'd0, out_carry, out_ovf, out_zero}, 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    do_single(vecs[0].op, vecs[0].a, vecs[0].b, 5'd3, vecs[0].r, vecs[0].c, vecs[0].o, vecs[0].z);
    for (int i = 1; i < 13; i++)
      do_single(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i), vecs[i].r, vecs[i].c, vecs[i].o, vecs[i].z);

    // Back-to-back ADD stream, consumer always ready.
    for (int i = 0; i < 8; i++)
      stim_q.push_back('{2'b00, 32'(i), 32'(i) * 32'h10000, 5'(i)});
    run_stream(0);
    chk("stream8_count", 32'(n_con), 32'd8);
    chk("stream8_latency", 32'(first_con - first_acc), 32'd2);
    chk("stream8_back_to_back", 32'(last_con - first_con), 32'd7);

    // Four mixed ops with the consumer stalled for five cycles.
    stim_q.push_back('{2'b01, 32'h00000010, 32'h00000003, 5'd20});
    stim_q.push_back('{2'b10, 32'hFFFFFFF0, 32'h00000002, 5'd21});
    stim_q.push_back('{2'b11, 32'hFFFFFFF0, 32'h00000002, 5'd22});
    stim_q.push_back('{2'b00, 32'hDEAD0000, 32'h0000BEEF, 5'd23});
    run_stream(5);
    chk("bp_count", 32'(n_con), 32'd4);
    chk("bp_first_out", 32'(first_con), 32'd5);

    // Reset with two ops in flight.
    in_valid = 1'b1; in_op = 2'b00; in_a = 32'd1; in_b = 32'd2; in_tag = 5'd30; out_ready = 1'b1;
    @(posedge clk); #1;
    in_a = 32'd3; in_b = 32'd4; in_tag = 5'd31;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_flush_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    do_single(2'b00, 32'h0000FFFF, 32'h00000001, 5'd9, 32'h00010000, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dsp_addsub_pipe.md
Name: dsp_addsub_pipe

Overview:
- Parametrised, pipelined integer add/subtract/compare unit for the sail-core ALU and branch path.
- Generalises the fixed 32-bit single-cycle DSP subtractor to WIDTH bits, split into CHUNK-bit slices with one register stage per slice (a pipelined carry chain).
- Adds selectable ADD/SUB/SLT/SLTU modes, carry/overflow/zero flags, a sideband tag, and valid/ready handshaking with backpressure.

Parameters:
- WIDTH, 32, operand and result width; must be a multiple of CHUNK.
- CHUNK, 16, slice width per pipeline stage (matches one DSP adder half).
- TAG_W, 5, width of the sideband tag carried alongside each operation (e.g. rd index).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  unit can accept this cycle.
- in_op  input  2  00 ADD, 01 SUB, 10 SLT (signed), 11 SLTU (unsigned).
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_tag  input  TAG_W  sideband tag.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_result  output  WIDTH  result.
- out_tag  output  TAG_W  tag of the result.
- out_carry  output  1  carry out of the MSB (SUB/compare: 1 = no borrow).
- out_ovf  output  1  signed overflow of the raw add/sub.
- out_zero  output  1  raw sum == 0 (for SLT/SLTU this means A == B).

Behaviour:
- Reset is the only reset source, sampled on clk; there is no asynchronous path.
- Reset values: all stage valid bits 0, out_valid 0; out_result, out_tag and all flags 0.
- Reset mid-operation discards every in-flight operation; no output is produced for any of them.
- NSTAGE = WIDTH/CHUNK. An elaboration-time error is required if WIDTH % CHUNK != 0 or CHUNK < 1.
- Raw operation: ADD computes A + B + 0. SUB, SLT and SLTU compute A + ~B + 1.
- Stage k (0..NSTAGE-1) adds slice k of the operands with the carry registered by stage k-1; stage 0 takes carry-in from the op.
- Unprocessed upper slices are skewed forward through the stages; completed lower result slices are carried forward.
- Latency: an operation accepted at edge t appears with out_valid = 1 after edge t+NSTAGE, given no stall. WIDTH=32/CHUNK=16 gives 2 cycles. Throughput is 1 operation per cycle.
- Flags are computed from the full raw sum in the last stage:
  - carry = carry out of bit WIDTH-1.
  - ovf = (A[msb] == B'[msb]) && (sum[msb] != A[msb]), where B' = B for ADD and ~B otherwise.
  - zero = (sum == 0).
- Result:
  - ADD/SUB: raw sum.
  - SLT: zero-extended (sum[msb] XOR ovf).
  - SLTU: zero-extended (~carry).
- Stall = out_valid && !out_ready. While stall is asserted every pipeline register holds, including the output registers and tag.
- in_ready = !stall, combinational. This is the only combinational input-to-output path.
- A transfer occurs on an edge where in_valid && in_ready. If in_valid = 0 and there is no stall, a bubble enters the pipeline. Bubbles are not collapsed.
- Output handshake: the result is consumed on an edge with out_valid && out_ready. If the next stage holds no valid data, out_valid falls on that same edge.
- Outputs are stable while out_valid && !out_ready; the bench must check this.
- Simultaneous consume and accept are both allowed in the same cycle.
- in_op, in_a, in_b and in_tag are don't-care when in_valid = 0.

Test Plan:
- Reset, then ADD 0x0000FFFF + 0x00000001, tag 3 -> two cycles later: out_valid = 1, result 0x00010000, carry 0, ovf 0, zero 0, tag 3. This exercises the inter-slice carry.
- SUB 0x80000000 - 0x00000001 -> result 0x7FFFFFFF, ovf 1, carry 1. SUB 5 - 5 -> result 0, zero 1, carry 1.
- SLT 0xFFFFFFFF vs 0x00000001 -> result 1. SLTU with the same operands -> result 0. SLTU 1 vs 2 -> result 1.
- Back-to-back stream of 8 ADDs (i + 0x10000*i, tags 0..7), out_ready = 1 -> 8 consecutive out_valid cycles, in order, with correct sums and tags.
- Stream of 4 ops with out_ready held 0 for 5 cycles -> in_ready drops once out_valid = 1, out_result is stable throughout, no op is lost or duplicated after out_ready returns.
- Assert rst for one cycle with 2 ops in flight -> out_valid stays 0 for the following NSTAGE cycles; the next op issued after reset completes normally with 2-cycle latency.
